// File: rtl/servo_pkg.sv
// Shared servo timing defaults, kept in one place so the generator and the
// decoder always agree on tick length and position offset.
package servo_pkg;

    localparam int unsigned SERVO_M             = 93;
    localparam int unsigned SERVO_OFFSET        = 46;
    localparam int unsigned POS_MAX             = 255;
    localparam int unsigned SERVO_TIMEOUT_TICKS = 2560;
    localparam int unsigned WIDTH_MAX           = 511;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/servo_pulse_decoder_tick_prescaler.sv
// Free-running 0..M-1 tick divider with a synchronous restart, so tick
// boundaries can be aligned to an external event such as a pulse start.
module tick_prescaler
    import servo_pkg::*;
#(
    parameter int unsigned M = SERVO_M
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    restart_i,
    output logic                    tick_o,
    output logic [cnt_width(M)-1:0] count_o
);

    localparam int unsigned CW = cnt_width(M);

    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    always_comb begin
        tick_o = (cnt_q == CW'(M - 1));
        cnt_d  = cnt_q + CW'(1);
        if (restart_i || tick_o) cnt_d = '0;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures servo pulse high time in prescaler ticks, rounds to the nearest
// tick and recovers the 8-bit position; flags bad pulses and loss of signal.
module servo_pulse_decoder
    import servo_pkg::*;
#(
    parameter int unsigned M             = SERVO_M,
    parameter int unsigned OFFSET        = SERVO_OFFSET,
    parameter int unsigned TIMEOUT_TICKS = SERVO_TIMEOUT_TICKS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       servo_in,
    output logic [7:0] pos,
    output logic       valid,
    output logic       err,
    output logic       lost
);

    localparam int unsigned CW     = cnt_width(M);
    localparam logic [11:0] TO_SAT = 12'(TIMEOUT_TICKS);

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        MEASURE
    } state_e;

    state_e        state_q, state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic          rise, fall, tick;
    logic [CW-1:0] presc;
    logic [8:0]    w_q, w_d;
    logic [11:0]   to_q, to_d;
    logic [7:0]    pos_q, pos_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          lost_q, lost_d;
    logic [9:0]    wr;
    logic          in_range;
    logic          stuck;

    // Synchroniser resets high: a line already high at reset release is
    // then never mistaken for a fresh rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= servo_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;
    assign fall = ~sync2_q & prev_q;

    tick_prescaler #(
        .M(M)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .restart_i (rise),
        .tick_o    (tick),
        .count_o   (presc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_LOW;
            w_q     <= '0;
            to_q    <= '0;
            pos_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            lost_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            to_q    <= to_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            lost_q  <= lost_d;
        end
    end

    // Partial tick at the fall rounds up once it reaches half a tick.
    assign wr       = {1'b0, w_q} + {9'd0, (presc >= CW'(M / 2))};
    assign in_range = (wr >= 10'(OFFSET)) && (wr <= 10'(OFFSET + POS_MAX));

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        pos_d   = pos_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        lost_d  = lost_q;
        to_d    = to_q;
        stuck   = 1'b0;

        if (tick && (to_q != TO_SAT)) to_d = to_q + 12'd1;

        case (state_q)
            WAIT_LOW: begin
                if (!sync2_q) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (rise) begin
                    w_d     = '0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (fall) begin
                    state_d = WAIT_RISE;
                    if (in_range) begin
                        pos_d   = 8'(wr - 10'(OFFSET));
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (w_q == 9'(WIDTH_MAX)) begin
                    stuck   = 1'b1;
                    err_d   = 1'b1;
                    state_d = WAIT_LOW;
                end else if (tick) begin
                    w_d = w_q + 9'd1;
                end
            end
            default: state_d = WAIT_LOW;
        endcase

        if (valid_d) begin
            to_d   = '0;
            lost_d = 1'b0;
        end else if (stuck || (to_d == TO_SAT)) begin
            lost_d = 1'b1;
        end
    end

    assign pos   = pos_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign lost  = lost_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Bench for servo_pulse_decoder: directed and random pulses against a
// round-to-nearest-tick model of the decoded position.
module tb_servo_pulse_decoder;

    localparam int unsigned TM   = 9;
    localparam int unsigned TOFF = 46;
    localparam int unsigned TTO  = 600;

    logic       clk = 1'b0;
    logic       rst;
    logic       servo_in;
    logic [7:0] pos;
    logic       valid, err, lost;

    int         checks = 0;
    int         errors = 0;
    int         valid_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] valid_pos = '0;
    int         pos_model = 0;

    servo_pulse_decoder #(
        .M             (TM),
        .OFFSET        (TOFF),
        .TIMEOUT_TICKS (TTO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .servo_in (servo_in),
        .pos      (pos),
        .valid    (valid),
        .err      (err),
        .lost     (lost)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid) begin
                valid_cnt++;
                valid_pos = pos;
            end
            if (err) err_cnt++;
            if (valid || err) begin
                checks++;
                if (valid && err) begin
                    errors++;
                    $display("FAIL strobe_exclusive: valid=%0b err=%0b, required not both", valid, err);
                end
            end
        end
    end

    // Nearest whole tick for a pulse of n clocks: floor(n/M + 1/2).
    function automatic int model_ticks(input int n);
        return (2 * n + TM) / (2 * TM);
    endfunction

    task automatic pulse(input int n, input int gap);
        @(negedge clk);
        servo_in = 1'b1;
        repeat (n) @(negedge clk);
        servo_in = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_check(input string name, input int n);
        int v0, e0, wr, expv;
        v0 = valid_cnt;
        e0 = err_cnt;
        wr = model_ticks(n);
        pulse(n, 20);
        if (wr >= TOFF && wr <= TOFF + 255) begin
            expv = wr - TOFF;
            checks++;
            if (valid_cnt - v0 !== 1 || err_cnt - e0 !== 0) begin
                errors++;
                $display("FAIL %s strobes: valid=%0d err=%0d, required 1/0", name, valid_cnt - v0, err_cnt - e0);
            end
            checks++;
            if (valid_pos !== 8'(expv)) begin
                errors++;
                $display("FAIL %s pos_at_valid: got %0d, required %0d", name, valid_pos, expv);
            end
            checks++;
            if (pos !== 8'(expv)) begin
                errors++;
                $display("FAIL %s pos_hold: got %0d, required %0d", name, pos, expv);
            end
            checks++;
            if (lost !== 1'b0) begin
                errors++;
                $display("FAIL %s lost: got %0b, required 0", name, lost);
            end
            pos_model = expv;
        end else begin
            checks++;
            if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 1) begin
                errors++;
                $display("FAIL %s strobes: valid=%0d err=%0d, required 0/1", name, valid_cnt - v0, err_cnt - e0);
            end
            checks++;
            if (pos !== 8'(pos_model)) begin
                errors++;
                $display("FAIL %s pos_unchanged: got %0d, required %0d", name, pos, pos_model);
            end
        end
    endtask

    task automatic test_reset;
        checks++;
        if (pos !== 8'd0 || valid !== 1'b0 || err !== 1'b0 || lost !== 1'b1) begin
            errors++;
            $display("FAIL reset_values: pos=%0d valid=%0b err=%0b lost=%0b, required 0/0/0/1", pos, valid, err, lost);
        end
    endtask

    task automatic test_first_pulse;
        checks++;
        if (lost !== 1'b1) begin
            errors++;
            $display("FAIL lost_before_first: got %0b, required 1", lost);
        end
        pulse_check("pos0", TOFF * TM);
    endtask

    task automatic test_range_edges;
        pulse_check("pos255", (255 + TOFF) * TM);
        pulse_check("pos128_round_down", (128 + TOFF) * TM + 4);
        pulse_check("pos129_round_up", (128 + TOFF) * TM + 5);
        pulse_check("tol_minus", (100 + TOFF) * TM - (TM / 2 - 1));
        pulse_check("tol_plus", (100 + TOFF) * TM + (TM / 2 - 1));
    endtask

    task automatic test_out_of_range;
        pulse_check("too_short", 40 * TM);
        pulse_check("too_long", 320 * TM);
    endtask

    task automatic test_timeout;
        int k;
        @(negedge clk);
        servo_in = 1'b1;
        repeat ((10 + TOFF) * TM) @(negedge clk);
        servo_in = 1'b0;
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (valid) break;
        end
        checks++;
        if (!valid) begin
            errors++;
            $display("FAIL timeout_seed_valid: valid=%0b within 10 cycles, required 1", valid);
        end
        pos_model = 10;
        repeat ((TTO - 2) * TM) @(negedge clk);
        checks++;
        if (lost !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: lost=%0b, required 0", lost);
        end
        repeat (4 * TM) @(negedge clk);
        checks++;
        if (lost !== 1'b1) begin
            errors++;
            $display("FAIL timeout_expired: lost=%0b, required 1", lost);
        end
        pulse_check("timeout_recover", (77 + TOFF) * TM);
    endtask

    task automatic test_stuck_high;
        int k, v0, e0;
        bit seen;
        v0 = valid_cnt;
        e0 = err_cnt;
        seen = 1'b0;
        @(negedge clk);
        servo_in = 1'b1;
        for (k = 0; k < 520 * TM; k++) begin
            @(negedge clk);
            if (err) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || lost !== 1'b1) begin
            errors++;
            $display("FAIL stuck_err_lost: err_seen=%0b lost=%0b, required 1/1", seen, lost);
        end
        repeat (520 * TM - k - 1) @(negedge clk);
        servo_in = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (err_cnt - e0 !== 1 || valid_cnt - v0 !== 0) begin
            errors++;
            $display("FAIL stuck_strobes: err=%0d valid=%0d, required 1/0", err_cnt - e0, valid_cnt - v0);
        end
        checks++;
        if (pos !== 8'(pos_model)) begin
            errors++;
            $display("FAIL stuck_pos: got %0d, required %0d", pos, pos_model);
        end
        pulse_check("after_stuck", 100 * TM);
    endtask

    task automatic test_reset_mid_pulse;
        int v0, e0;
        @(negedge clk);
        servo_in = 1'b1;
        repeat (50 * TM) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset;
        pos_model = 0;
        v0 = valid_cnt;
        e0 = err_cnt;
        rst = 1'b0;
        repeat (60 * TM) @(negedge clk);
        servo_in = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (valid_cnt - v0 !== 0 || err_cnt - e0 !== 0) begin
            errors++;
            $display("FAIL reset_mid_pulse: valid=%0d err=%0d, required 0/0", valid_cnt - v0, err_cnt - e0);
        end
        pulse_check("after_reset", (60 + TOFF) * TM);
    endtask

    task automatic test_random;
        int n;
        for (int i = 0; i < 10; i++) begin
            n = int'($urandom_range(35 * TM, 320 * TM));
            pulse_check($sformatf("random%0d_n%0d", i, n), n);
        end
    endtask

    task automatic test_loopback;
        int vals[5] = '{0, 1, 127, 254, 255};
        for (int i = 0; i < 5; i++) begin
            for (int f = 0; f < 2; f++) begin
                pulse_check($sformatf("loopback_p%0d_f%0d", vals[i], f), (vals[i] + TOFF) * TM);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        servo_in = 1'b0;
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        test_first_pulse;
        test_range_edges;
        test_out_of_range;
        test_timeout;
        test_stuck_high;
        test_reset_mid_pulse;
        test_random;
        test_loopback;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
